// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage types: divider opcodes, divider FSM states, iteration count.
// Latency: none (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  // Values match funct3[1:0] of the RV32M divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // One quotient bit is resolved per CALC cycle.
  localparam int DIV_ITER = 32;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   rem_in  [W:0]   partial remainder before the step
//   bit_in          next dividend bit (MSB first)
//   dvs     [W-1:0] divisor magnitude
//   rem_out [W:0]   partial remainder after the step
//   q_bit           quotient bit produced by this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] wide;

  // The full shifted value is compared so the trial never wraps; after a
  // successful subtract the difference always fits back into W+1 bits.
  assign wide    = {rem_in, bit_in};
  assign q_bit   = (wide >= {2'b00, dvs});
  assign rem_out = q_bit ? (wide[W:0] - {1'b0, dvs}) : wide[W:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, restoring radix-2, one quotient bit per cycle.
// Latency: done 34 cycles after an accepted start; divide-by-zero/overflow done after 1 cycle.
// Backpressure: start accepted only in IDLE; busy holds the pipeline during CALC and FIX.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, op, a, b   request pulse, funct3[1:0] opcode, dividend, divisor (sampled with start)
//   busy              high while CALC/FIX are in progress
//   done, result      one-cycle completion pulse; result held until the next accepted start
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nxt;
  logic [4:0]      count;
  logic [XLEN-1:0] dvd;      // dividend magnitude, shifted out MSB first
  logic [XLEN-1:0] dvs;      // divisor magnitude
  logic [XLEN-1:0] quot;
  logic [XLEN:0]   rem;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  // Request decode, only meaningful in IDLE.
  logic            is_signed;
  logic            a_neg, b_neg;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] special_res;

  assign is_signed = (div_op_e'(op) == DIV) || (div_op_e'(op) == REM);
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign mag_a     = a_neg ? (~a + 1'b1) : a;
  assign mag_b     = b_neg ? (~b + 1'b1) : b;
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == INT_MIN) && (b == '1);
  assign special   = div_zero | ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : INT_MIN;
    end
  end

  // Datapath step.
  logic [XLEN:0] step_rem;
  logic          step_q;

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction; the final remainder is always below the divisor, so the
  // top bit of rem is zero by the time FIX runs.
  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = neg_q ? (~quot + 1'b1) : quot;
  assign r_fix = neg_r ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : CALC;
      CALC: if (count == 5'd0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      quot   <= '0;
      rem    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dvd    <= mag_a;
            dvs    <= mag_b;
            quot   <= '0;
            rem    <= '0;
            count  <= 5'(DIV_ITER - 1);
            if (special) result <= special_res;
          end
        end
        CALC: begin
          rem   <= step_rem;
          quot  <= {quot[XLEN-2:0], step_q};
          dvd   <= {dvd[XLEN-2:0], 1'b0};
          count <= count - 5'd1;
        end
        FIX: begin
          result <= is_rem ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed cases plus randomized ops against a plain-arithmetic model.
// Latency: checks 34-cycle normal and 1-cycle special-case completion.
// Backpressure: checks start is ignored while busy and that reset aborts an operation.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics expressed with ordinary integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int sx, sy, q, r;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) begin
      sx = x;
      sy = y;
      q  = sx / sy;
      r  = sx % sy;
      return o[1] ? 32'(r) : 32'(q);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Issue one op, scramble inputs after the start cycle, optionally re-assert
  // start at cycle N+inj, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, output logic [31:0] res, output int lat,
                        output int bcyc);
    res  = '0;
    lat  = -1;
    bcyc = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      if (busy) bcyc++;
      if (done) begin
        lat = k;
        res = result;
      end
      if (k == inj) begin
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd999;
        b     = 32'd10;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("result_hold", result, res);
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x, y, exp;
    int          lat;
  } dir_t;

  dir_t dir_tab[8] = '{
    '{2'b01, 32'd100,       32'd7,         32'd14,        34},
    '{2'b11, 32'd100,       32'd7,         32'd2,         34},
    '{2'b00, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34},
    '{2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34},
    '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
    '{2'b11, 32'd5,         32'd0,         32'd5,         1},
    '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1}
  };

  initial begin
    logic [31:0] res, x, y, exp_r;
    logic [1:0]  o;
    int          lat, bc, exp_lat;
    bit          saw_done;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    foreach (dir_tab[i]) begin
      run_op(dir_tab[i].o, dir_tab[i].x, dir_tab[i].y, 0, res, lat, bc);
      check($sformatf("dir%0d_result", i), res, dir_tab[i].exp);
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir_tab[i].lat));
      check($sformatf("dir%0d_busy_cycles", i), 32'(bc), (dir_tab[i].lat == 1) ? 32'd0 : 32'd33);
    end

    // start re-asserted mid-operation must be ignored.
    run_op(2'b01, 32'd100, 32'd7, 10, res, lat, bc);
    check("ignore_start_result", res, 32'd14);
    check("ignore_start_latency", 32'(lat), 32'd34);
    check("ignore_start_busy", 32'(bc), 32'd33);

    // Reset at edge N+20, in the middle of CALC.
    @(negedge clk);
    op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 19) reset = 1'b1;
    end
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midreset_no_done", 32'(saw_done), 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0, res, lat, bc);
    check("after_reset_result", res, 32'hFFFF_FFFF);
    check("after_reset_latency", 32'(lat), 32'd34);

    // Randomized ops with biased corner cases.
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 200));
        4: y = 32'd0 - 32'($urandom_range(1, 9));
        5: begin x = 32'd0 - 32'($urandom_range(0, 500)); y = 32'($urandom_range(1, 40)); end
        default: ;
      endcase
      exp_r   = ref_model(o, x, y);
      exp_lat = is_special(o, x, y) ? 1 : 34;
      run_op(o, x, y, 0, res, lat, bc);
      check($sformatf("rnd%0d_op%0d_%h_%h_result", i, o, x, y), res, exp_r);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("rnd%0d_busy_cycles", i), 32'(bc), (exp_lat == 1) ? 32'd0 : 32'd33);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage beside the ALU. Its `result` drives one data input of the 10-input writeback/result select mux. The pipeline stalls while `busy` is high. A restoring radix-2 algorithm resolves one quotient bit per cycle, and RISC-V special cases complete early.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  XLEN  dividend; sampled with `start`.
- `b`  in  XLEN  divisor; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive of the cycle before `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  quotient or remainder; held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `start`=1, latch `op`, `a`, `b`.
  - If b==0 or signed overflow, go to DONE. Signed overflow is op signed and a=0x8000_0000 and b=0xFFFF_FFFF.
  - Otherwise go to CALC with count=31.
- **Signed ops**
  - Convert operands to magnitudes.
  - Record quotient sign = sign(a) XOR sign(b).
  - Record remainder sign = sign(a).
- **CALC**
  - Each cycle: shift the 33-bit partial remainder left, bringing in the next dividend bit. Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise set it to 0.
  - Exit to FIX after count reaches 0, i.e. after 32 iterations.
- **FIX**
  - Apply sign correction by two's complement.
  - Select the quotient (op[1]=0) or the remainder (op[1]=1) into `result`.
  - Go to DONE.
- **Special-case results**, set on IDLE→DONE:
  - Divide by zero: quotient = 0xFFFF_FFFF; remainder = a.
  - Overflow: quotient = 0x8000_0000; remainder = 0.
- **DONE**
  - `done`=1 for exactly one cycle.
  - Return to IDLE. A `start` in this cycle is ignored.
- `start` while not in IDLE is ignored, with no effect on the operation in flight.
- All arithmetic is unsigned on magnitudes. The partial remainder is 33 bits wide, so no overflow is possible.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `result`=0, internal registers 0.
- **Normal latency:** `start` sampled at edge N.
  - CALC occupies cycles N+1..N+32.
  - FIX occupies cycle N+33.
  - DONE occupies cycle N+34, with `done`=1 and `result` valid.
  - `busy`=1 during cycles N+1..N+33.
- **Special-case latency:** `done`=1 and `result` valid in cycle N+1. `busy` stays 0.
- **Back-to-back:** the earliest next `start` accepted is in the cycle after DONE, when the FSM is back in IDLE.
- **Reset mid-operation:** `reset`=1 at any edge returns the block to reset values at that edge. The pending operation is discarded and no `done` is produced.
- **Reset and start together:** `reset` wins.
- **Operand stability:** `a`, `b`, `op` may change after the `start` cycle without effect.

## Structure
- Shared package `riscv_pkg` holds:
  - `div_op_e` enum (DIV, DIVU, REM, REMU = 2'b00..2'b11);
  - `div_state_e` enum;
  - constant `DIV_ITER = 32`.
- One sub-module, `div_step`: combinational shift-and-trial-subtract.
  - Inputs: 33-bit remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- The FSM, sign handling and result register stay in `div_unit`.

## Test plan
- DIVU a=100, b=7 → `done` at N+34, `result`=14. REMU with the same operands → `result`=2.
- DIV a=-100 (0xFFFF_FF9C), b=7 → `result`=0xFFFF_FFF2 (-14). REM with the same operands → `result`=0xFFFF_FFFE (-2).
- DIV a=5, b=0 → `done` at N+1, `result`=0xFFFF_FFFF. REMU a=5, b=0 → `result`=5.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → `done` at N+1, `result`=0x8000_0000. REM with the same operands → `result`=0.
- Assert `start` again with new operands at N+10 → ignored. `result` is still that of the first op at N+34, and `busy` is continuous.
- Assert `reset` at N+20 mid-CALC → `busy`=0, `result`=0, no `done` pulse. A fresh DIVU 0xFFFF_FFFF / 1 then returns 0xFFFF_FFFF.
